// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_seq_pkg;

    // Bring-up sequencer states
    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        FAIL
    } state_t;

    // Width of the saturating lock-loss counter
    localparam int LOSS_CNT_W = 8;

endpackage

// File: rtl/lock_sync.sv
// Two-flop synchronizer for the PLL locked indication.
// Only compiled when PLL_LOCK_SYNC_EN is defined; the sequencer uses the raw
// locked input otherwise, so this module has no user in the default build.
`ifdef PLL_LOCK_SYNC_EN
module lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Resample the asynchronous input twice; both flops clear to "not locked"
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`endif

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, qualifies lock, then releases
// the per-domain resets one at a time. Handles lock timeout with retries,
// lock loss after release, and software relock requests.
// Optional macro PLL_LOCK_SYNC_EN: route pll_locked through a 2-flop
// synchronizer (lock-related transitions then lag by two refclk cycles).
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int NUM_DOMAINS         = 5,
    parameter int RST_CYCLES          = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int STAGGER_CYCLES      = 8,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                               refclk,
    input  logic                               rst,
    input  logic                               pll_locked,
    input  logic                               relock_req,
    output logic                               pll_rst,
    output logic [NUM_DOMAINS-1:0]             domain_rst,
    output logic                               ready,
    output logic                               fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
    output logic [LOSS_CNT_W-1:0]              lock_loss_cnt
);

    // One shared cycle counter, sized for the longest interval it must time
    localparam int MAX_AB  = (RST_CYCLES > LOCK_STABLE_CYCLES) ? RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_CD  = (LOCK_TIMEOUT_CYCLES > STAGGER_CYCLES) ? LOCK_TIMEOUT_CYCLES : STAGGER_CYCLES;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam int RW      = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [RW-1:0]    RETRY_LIMIT  = RW'(MAX_RETRIES);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             locked_s;

    // Saturating increment so the loss count sticks at all ones
    function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
        return (v == {LOSS_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

`ifdef PLL_LOCK_SYNC_EN
    lock_sync u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );
`else
    assign locked_s = pll_locked;
`endif

    // Sequencer FSM; every output is registered alongside the state
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state         <= RESET_PLL;
            cnt           <= '0;
            idx           <= '0;
            pll_rst       <= 1'b1;
            domain_rst    <= '1;
            ready         <= 1'b0;
            fail          <= 1'b0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
        end else if (relock_req) begin
            // Relock wins over everything but reset and never counts as a loss
            state      <= RESET_PLL;
            cnt        <= '0;
            idx        <= '0;
            pll_rst    <= 1'b1;
            domain_rst <= '1;
            ready      <= 1'b0;
            fail       <= 1'b0;
            retry_cnt  <= '0;
        end else if ((state == RELEASE || state == RUN) && !locked_s) begin
            // Lock lost after release began: pull every domain back into reset
            state         <= RESET_PLL;
            cnt           <= '0;
            idx           <= '0;
            pll_rst       <= 1'b1;
            domain_rst    <= '1;
            ready         <= 1'b0;
            retry_cnt     <= '0;
            lock_loss_cnt <= sat_inc(lock_loss_cnt);
        end else begin
            case (state)
                RESET_PLL: begin
                    pll_rst <= 1'b1;
                    if (cnt == RST_LAST) begin
                        state   <= WAIT_LOCK;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt <= '0;
                        if (retry_cnt == RETRY_LIMIT) begin
                            state      <= FAIL;
                            pll_rst    <= 1'b1;
                            domain_rst <= '1;
                            fail       <= 1'b1;
                        end else begin
                            state     <= RESET_PLL;
                            pll_rst   <= 1'b1;
                            retry_cnt <= retry_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STABLE: begin
                    // Any dropout restarts both qualification and the timeout
                    if (!locked_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state <= RELEASE;
                        cnt   <= '0;
                        idx   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt == STAGGER_LAST) begin
                        cnt             <= '0;
                        domain_rst[idx] <= 1'b0;
                        if (idx == IDX_LAST) begin
                            state     <= RUN;
                            ready     <= 1'b1;
                            retry_cnt <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                FAIL: begin
                    pll_rst    <= 1'b1;
                    domain_rst <= '1;
                    fail       <= 1'b1;
                end
                default: begin
                    state   <= RESET_PLL;
                    cnt     <= '0;
                    pll_rst <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed testbench for pll_reset_sequencer with short timing parameters.
module tb_pll_reset_sequencer;

    localparam int NUM_DOMAINS         = 5;
    localparam int RST_CYCLES          = 4;
    localparam int LOCK_STABLE_CYCLES  = 8;
    localparam int LOCK_TIMEOUT_CYCLES = 32;
    localparam int STAGGER_CYCLES      = 2;
    localparam int MAX_RETRIES         = 2;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic [4:0] domain_rst;
    logic       ready;
    logic       fail;
    logic [1:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int checks   = 0;
    int failures = 0;

    pll_reset_sequencer #(
        .NUM_DOMAINS         (NUM_DOMAINS),
        .RST_CYCLES          (RST_CYCLES),
        .LOCK_STABLE_CYCLES  (LOCK_STABLE_CYCLES),
        .LOCK_TIMEOUT_CYCLES (LOCK_TIMEOUT_CYCLES),
        .STAGGER_CYCLES      (STAGGER_CYCLES),
        .MAX_RETRIES         (MAX_RETRIES)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .relock_req    (relock_req),
        .pll_rst       (pll_rst),
        .domain_rst    (domain_rst),
        .ready         (ready),
        .fail          (fail),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Advance n rising edges, then settle 1 time unit past the edge
    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    // Apply reset for two edges; the next rising edge is edge 1 of the sequence
    task automatic do_reset();
        rst        = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        tick(3);
        checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL reset_pll_rst got=%b want=1", pll_rst); end
        checks++; if (domain_rst !== 5'h1F) begin failures++; $display("FAIL reset_domain_rst got=%h want=1f", domain_rst); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", ready); end
        checks++; if (fail !== 1'b0) begin failures++; $display("FAIL reset_fail got=%b want=0", fail); end
        checks++; if (retry_cnt !== 2'd0) begin failures++; $display("FAIL reset_retry got=%0d want=0", retry_cnt); end
        checks++; if (lock_loss_cnt !== 8'd0) begin failures++; $display("FAIL reset_loss got=%0d want=0", lock_loss_cnt); end
    endtask

    // Lock at edge 10 -> STABLE at 11, RELEASE at 19, bit k-1 clears at 19+2k
    task automatic test_bringup();
        int k;
        logic [4:0] exp_dom;
        logic exp_prst;
        logic exp_rdy;
        do_reset();
        for (int e = 1; e <= 29; e++) begin
            tick(1);
            if (e == 10) pll_locked = 1'b1;
            k        = (e >= 21) ? (e - 19) / 2 : 0;
            exp_dom  = 5'h1F << k;
            exp_prst = (e < 4);
            exp_rdy  = (k == 5);
            checks++; if (pll_rst !== exp_prst) begin failures++; $display("FAIL bringup_pll_rst e=%0d got=%b want=%b", e, pll_rst, exp_prst); end
            checks++; if (domain_rst !== exp_dom) begin failures++; $display("FAIL bringup_domain e=%0d got=%h want=%h", e, domain_rst, exp_dom); end
            checks++; if (ready !== exp_rdy) begin failures++; $display("FAIL bringup_ready e=%0d got=%b want=%b", e, ready, exp_rdy); end
        end
        checks++; if (retry_cnt !== 2'd0) begin failures++; $display("FAIL bringup_retry got=%0d want=0", retry_cnt); end
    endtask

    // Drop at STABLE cnt 5 (edge 17 samples 0), relock seen at 18 -> RELEASE 26
    task automatic test_stable_glitch();
        int k;
        logic [4:0] exp_dom;
        logic exp_prst;
        do_reset();
        for (int e = 1; e <= 30; e++) begin
            tick(1);
            if (e == 10) pll_locked = 1'b1;
            if (e == 16) pll_locked = 1'b0;
            if (e == 17) pll_locked = 1'b1;
            k        = (e >= 28) ? (e - 26) / 2 : 0;
            exp_dom  = 5'h1F << k;
            exp_prst = (e < 4);
            checks++; if (domain_rst !== exp_dom) begin failures++; $display("FAIL glitch_domain e=%0d got=%h want=%h", e, domain_rst, exp_dom); end
            checks++; if (pll_rst !== exp_prst) begin failures++; $display("FAIL glitch_pll_rst e=%0d got=%b want=%b", e, pll_rst, exp_prst); end
        end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL glitch_ready got=%b want=0", ready); end
        checks++; if (lock_loss_cnt !== 8'd0) begin failures++; $display("FAIL glitch_loss got=%0d want=0", lock_loss_cnt); end
    endtask

    // Attempts start at edges 0, 36, 72; FAIL entered at edge 108
    task automatic test_timeout_fail();
        logic exp_prst;
        logic exp_fail;
        logic [1:0] exp_retry;
        do_reset();
        for (int e = 1; e <= 108; e++) begin
            tick(1);
            exp_prst  = (e < 4) || (e >= 36 && e < 40) || (e >= 72 && e < 76) || (e >= 108);
            exp_retry = (e >= 72) ? 2'd2 : ((e >= 36) ? 2'd1 : 2'd0);
            exp_fail  = (e >= 108);
            checks++; if (pll_rst !== exp_prst) begin failures++; $display("FAIL timeout_pll_rst e=%0d got=%b want=%b", e, pll_rst, exp_prst); end
            checks++; if (retry_cnt !== exp_retry) begin failures++; $display("FAIL timeout_retry e=%0d got=%0d want=%0d", e, retry_cnt, exp_retry); end
            checks++; if (fail !== exp_fail) begin failures++; $display("FAIL timeout_fail e=%0d got=%b want=%b", e, fail, exp_fail); end
            checks++; if (domain_rst !== 5'h1F) begin failures++; $display("FAIL timeout_domain e=%0d got=%h want=1f", e, domain_rst); end
        end
        for (int c = 0; c < 100; c++) begin
            tick(1);
            checks++; if (fail !== 1'b1) begin failures++; $display("FAIL hold_fail c=%0d got=%b want=1", c, fail); end
            checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL hold_pll_rst c=%0d got=%b want=1", c, pll_rst); end
            checks++; if (domain_rst !== 5'h1F) begin failures++; $display("FAIL hold_domain c=%0d got=%h want=1f", c, domain_rst); end
            checks++; if (retry_cnt !== 2'd2) begin failures++; $display("FAIL hold_retry c=%0d got=%0d want=2", c, retry_cnt); end
            checks++; if (ready !== 1'b0) begin failures++; $display("FAIL hold_ready c=%0d got=%b want=0", c, ready); end
        end
    endtask

    // From FAIL: relock at edge 0, ready expected exactly 23 edges later
    task automatic test_recovery();
        int n;
        pll_locked = 1'b1;
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        checks++; if (fail !== 1'b0) begin failures++; $display("FAIL recov_fail got=%b want=0", fail); end
        checks++; if (retry_cnt !== 2'd0) begin failures++; $display("FAIL recov_retry got=%0d want=0", retry_cnt); end
        checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL recov_pll_rst got=%b want=1", pll_rst); end
        checks++; if (domain_rst !== 5'h1F) begin failures++; $display("FAIL recov_domain got=%h want=1f", domain_rst); end
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            tick(1);
            n = i;
            if (ready === 1'b1) break;
        end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL recov_ready_timeout got=%b want=1", ready); end
        checks++; if (n != 23) begin failures++; $display("FAIL recov_latency got=%0d want=23", n); end
        checks++; if (domain_rst !== 5'h00) begin failures++; $display("FAIL recov_domain_run got=%h want=00", domain_rst); end
        checks++; if (pll_rst !== 1'b0) begin failures++; $display("FAIL recov_pll_rst_run got=%b want=0", pll_rst); end
    endtask

    // Starts in RUN; RESET_PLL->RELEASE takes 13 edges, so drop lock on the 15th
    task automatic test_lock_loss();
        logic [7:0] exp_loss;
        pll_locked = 1'b0;
        tick(1);
        checks++; if (domain_rst !== 5'h1F) begin failures++; $display("FAIL loss_domain got=%h want=1f", domain_rst); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL loss_ready got=%b want=0", ready); end
        checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL loss_pll_rst got=%b want=1", pll_rst); end
        checks++; if (lock_loss_cnt !== 8'd1) begin failures++; $display("FAIL loss_cnt_first got=%0d want=1", lock_loss_cnt); end
        checks++; if (retry_cnt !== 2'd0) begin failures++; $display("FAIL loss_retry got=%0d want=0", retry_cnt); end

        // Relock together with lock loss must not count a loss
        pll_locked = 1'b1;
        tick(14);
        checks++; if (pll_rst !== 1'b0) begin failures++; $display("FAIL both_pre_pll_rst got=%b want=0", pll_rst); end
        relock_req = 1'b1;
        pll_locked = 1'b0;
        tick(1);
        relock_req = 1'b0;
        checks++; if (lock_loss_cnt !== 8'd1) begin failures++; $display("FAIL both_loss_cnt got=%0d want=1", lock_loss_cnt); end
        checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL both_pll_rst got=%b want=1", pll_rst); end

        for (int i = 2; i <= 256; i++) begin
            pll_locked = 1'b1;
            tick(14);
            pll_locked = 1'b0;
            tick(1);
            exp_loss = (i > 255) ? 8'd255 : 8'(i);
            checks++; if (lock_loss_cnt !== exp_loss) begin failures++; $display("FAIL loss_cnt i=%0d got=%0d want=%0d", i, lock_loss_cnt, exp_loss); end
        end
        checks++; if (domain_rst !== 5'h1F) begin failures++; $display("FAIL loss_sat_domain got=%h want=1f", domain_rst); end
    endtask

    // Reach RELEASE with two domains out, then assert rst between edges
    task automatic test_async_rst();
        do_reset();
        for (int e = 1; e <= 24; e++) begin
            tick(1);
            if (e == 10) pll_locked = 1'b1;
        end
        checks++; if (domain_rst !== 5'h1C) begin failures++; $display("FAIL arst_pre_domain got=%h want=1c", domain_rst); end
        #3;
        rst = 1'b1;
        #1;
        checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL arst_pll_rst got=%b want=1", pll_rst); end
        checks++; if (domain_rst !== 5'h1F) begin failures++; $display("FAIL arst_domain got=%h want=1f", domain_rst); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL arst_ready got=%b want=0", ready); end
        checks++; if (fail !== 1'b0) begin failures++; $display("FAIL arst_fail got=%b want=0", fail); end
        checks++; if (retry_cnt !== 2'd0) begin failures++; $display("FAIL arst_retry got=%0d want=0", retry_cnt); end
        pll_locked = 1'b0;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        test_reset();
        test_bringup();
        test_stable_glitch();
        test_timeout_fail();
        test_recovery();
        test_lock_loss();
        test_async_rst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
